// File: rtl/vpu_sram_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vpu_sram_wr_ctrl
// Description : Single-outstanding SRAM write controller placed downstream of
//               the VPU write-back unit. Waits for the target bank to be free
//               of other masters, issues a one-cycle active-low write strobe,
//               then returns a one-cycle ack. Keeps saturating write/stall
//               counters and a sticky out-of-range bank error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_sram_wr_ctrl #(
  parameter int SRAM_BANK_CNT       = 4,
  parameter int SRAM_BANK_CNT_LG2   = 2,
  parameter int SRAM_BANK_DEPTH_LG2 = 10,
  parameter int SRAM_DATA_WIDTH     = 512,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_i,
  input  logic [SRAM_BANK_CNT_LG2-1:0]   wid_i,
  input  logic [SRAM_BANK_DEPTH_LG2-1:0] addr_i,
  input  logic                           web_i,
  input  logic                           wlast_i,
  input  logic [SRAM_DATA_WIDTH-1:0]     wdata_i,
  output logic                           ack_o,
  input  logic [SRAM_BANK_CNT-1:0]       bank_busy_i,
  output logic [SRAM_BANK_CNT-1:0]       bank_csb_o,
  output logic                           bank_web_o,
  output logic [SRAM_BANK_DEPTH_LG2-1:0] bank_addr_o,
  output logic [SRAM_DATA_WIDTH-1:0]     bank_wdata_o,
  output logic [CNT_WIDTH-1:0]           wr_cnt_o,
  output logic [CNT_WIDTH-1:0]           stall_cnt_o,
  output logic                           err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  // Bank count widened by one bit so the range check also works when the
  // bank count is not a power of two.
  localparam logic [SRAM_BANK_CNT_LG2:0] c_bank_cnt = SRAM_BANK_CNT[SRAM_BANK_CNT_LG2:0];

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [SRAM_BANK_CNT_LG2-1:0]     r_wid_q;
  logic                             r_wlast_q;
  logic [SRAM_BANK_DEPTH_LG2-1:0]   r_addr_q;
  logic [SRAM_DATA_WIDTH-1:0]       r_wdata_q;
  logic [CNT_WIDTH-1:0]             r_wr_cnt;
  logic [CNT_WIDTH-1:0]             r_stall_cnt;
  logic                             r_err;

  logic                             w_wid_oor;
  logic                             w_accept;
  logic                             w_accept_wr;
  logic                             w_sel_busy;
  logic                             w_strobe;
  logic                             w_stall;
  logic [SRAM_BANK_CNT-1:0]         w_csb;
  logic                             w_unused;

  assign w_wid_oor   = ({1'b0, wid_i} >= c_bank_cnt);
  assign w_accept    = (r_state == S_IDLE) && req_i;
  // Only real, in-range writes reach the bank; no-ops and bad ids bypass it.
  assign w_accept_wr = w_accept && !web_i && !w_wid_oor;
  assign w_strobe    = (r_state == S_WRITE) && !w_sel_busy;
  assign w_stall     = (r_state == S_WRITE) && w_sel_busy;

  // wlast is carried for future burst support and has no effect yet.
  assign w_unused = r_wlast_q;

  // Busy bit of the latched target bank (zero for ids with no bank).
  always_comb begin
    w_sel_busy = 1'b0;
    for (int i = 0; i < SRAM_BANK_CNT; i++) begin
      if (r_wid_q == SRAM_BANK_CNT_LG2'(i)) w_sel_busy = bank_busy_i[i];
    end
  end

  // Chip selects: at most one bit low, only on the cycle the write fires.
  always_comb begin
    w_csb = '1;
    for (int i = 0; i < SRAM_BANK_CNT; i++) begin
      if (w_strobe && (r_wid_q == SRAM_BANK_CNT_LG2'(i))) w_csb[i] = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_i) w_state_nxt = (web_i || w_wid_oor) ? S_ACK : S_WRITE;
      S_WRITE: if (!w_sel_busy) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture; the address/data copy doubles as the held bank bus value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wid_q   <= '0;
      r_wlast_q <= 1'b0;
      r_addr_q  <= '0;
      r_wdata_q <= '0;
    end else begin
      if (w_accept) begin
        r_wid_q   <= wid_i;
        r_wlast_q <= wlast_i;
      end
      if (w_accept_wr) begin
        r_addr_q  <= addr_i;
        r_wdata_q <= wdata_i;
      end
    end
  end

  // Saturating debug counters and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt    <= '0;
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_strobe && !(&r_wr_cnt))   r_wr_cnt    <= r_wr_cnt + CNT_WIDTH'(1);
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      if (w_accept && w_wid_oor)      r_err       <= 1'b1;
    end
  end

  assign ack_o        = (r_state == S_ACK);
  assign bank_csb_o   = w_csb;
  assign bank_web_o   = !w_strobe;
  assign bank_addr_o  = r_addr_q;
  assign bank_wdata_o = r_wdata_q;
  assign wr_cnt_o     = r_wr_cnt;
  assign stall_cnt_o  = r_stall_cnt;
  assign err_o        = r_err;

endmodule
`default_nettype wire
